div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit radix-2 restoring divider. It serves the EX stage's divide request handshake (`start_i`/`annul_i` in, `ready_o`/`result_o` out) for MIPS `div`/`divu`. The divider latches the operands on start and produces one quotient bit per cycle. It presents `{remainder, quotient}` for exactly one cycle, which EX writes into HI/LO. While `ready_o` is low, EX holds `start_i` and the operands stable and stalls the pipeline.

## Interface
Parameters: none. Widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `signed_div_i`  in  1  — 1 selects a signed (`div`) operation, 0 selects unsigned (`divu`). Sampled on start.
- `opdata1_i`  in  32  — dividend. Sampled on start.
- `opdata2_i`  in  32  — divisor. Sampled on start.
- `start_i`  in  1  — `DivStart`/`DivStop`. The requester holds it high until it sees `ready_o`.
- `annul_i`  in  1  — abort the operation in flight.
- `result_o`  out  64  — `{remainder[31:0], quotient[31:0]}`.
- `ready_o`  out  1  — `DivResultReady` when `result_o` is valid.

## Operation
The FSM has four states; encodings live in `defines.vh`:
- **DivFree**
  - When `start_i` = 1 and `annul_i` = 0:
    - divisor = 0 → **DivByZero**.
    - divisor ≠ 0 → **DivOn**. On this transition the block latches magnitudes: `|op|` if `signed_div_i` is set, raw otherwise. It clears the 6-bit iteration counter and loads the 65-bit working register with `{33'b0, |dividend|}`.
- **DivByZero** → **DivEnd** with quotient = remainder = 0. MIPS leaves this result undefined; this block defines it as zero.
- **DivOn**, one step per cycle:
  - Shift the working register left by 1.
  - Trial-subtract the divisor from bits [64:32] as a 33-bit operation.
  - If the difference is non-negative, replace the upper part with the difference and set quotient bit 0 to 1; otherwise keep the shifted value and set bit 0 to 0.
  - After the 32nd step (counter = 31), apply sign fixup and go to **DivEnd**:
    - Negate the quotient if `signed_div_i` is set and the dividend sign differs from the divisor sign.
    - Negate the remainder if `signed_div_i` is set and the dividend is negative.
  - If `annul_i` = 1 or `start_i` = 0 in any DivOn cycle → **DivFree**. `ready_o` stays 0 and the result is discarded.
- **DivEnd**
  - `ready_o` = 1 and `result_o` is valid.
  - `start_i` = 0 → **DivFree**, with `ready_o` = 0 and `result_o` = 0 next cycle.
  - `start_i` still 1 → remain in **DivEnd** and hold the result.

Arithmetic rules:
- Magnitudes are 32-bit unsigned. `|0x80000000|` = `0x80000000` is valid in the 33-bit subtractor.
- `0x80000000 / 0xFFFFFFFF` signed → quotient `0x80000000`, remainder 0. This is two's-complement wrap with no exception.

## Timing
- Reset: `rst` = 1 at an edge → DivFree, `ready_o` = 0, `result_o` = 0, counter = 0. Reset in mid-operation abandons the operation silently.
- Start is sampled at edge t:
  - Normal operation: DivOn during cycles t+1 … t+32; `ready_o` = 1 in cycle t+33. Latency is 33 cycles.
  - Divide by zero: `ready_o` = 1 in cycle t+2.
- `ready_o` is a registered output, high only in DivEnd.
  - EX drops `start_i` in the same cycle it sees `ready_o`, so `ready_o` lasts exactly 1 cycle.
  - A new start is accepted no earlier than 1 cycle after DivEnd.
- `annul_i` and `start_i` together in DivFree: annul wins and the block stays in DivFree.
- Operand changes after the start cycle are ignored.

## Configuration
- Macro: `DIV_EARLY_EXIT_EN`.
- Defined: in DivFree, if divisor ≠ 0 and `|dividend|` < `|divisor|` (unsigned compare of magnitudes):
  - Go straight to **DivEnd** with quotient 0 and remainder = `opdata1_i` (its original sign).
  - `ready_o` = 1 in cycle t+2.
- Undefined: every non-zero-divisor operation takes the full 33 cycles.
- The handshake is identical in both builds.

## Structure
- In `defines.vh`:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit).
  - `DivStart`/`DivStop`, `DivResultReady`/`DivResultNotReady`.
  - `ZeroWord`.
- Single flat module with no sub-module. The abs/negate helpers are inline expressions; a separate block is not worth it at this size.

## Test plan
- `divu` `100 / 7` with `start_i` held → `ready_o` = 1 exactly 33 cycles after the start edge, `result_o` = `{32'd2, 32'd14}`; `ready_o` drops 1 cycle after `start_i` drops.
- `div` `-7 / 2` (`0xFFFFFFF9`, 2) → `result_o` = `{0xFFFFFFFF, 0xFFFFFFFD}`; `div` `0x80000000 / 0xFFFFFFFF` → `{0, 0x80000000}`.
- Divisor 0, dividend `0x1234` → `ready_o` at t+2, `result_o` = 64'b0.
- `annul_i` pulsed at cycle t+10 of a `divu` → DivFree next cycle, `ready_o` never rises. A new start 2 cycles later computing `0xFFFFFFFF / 0x10` → `{0xF, 0x0FFFFFFF}`.
- `rst` asserted at cycle t+20 → next cycle `ready_o` = 0, `result_o` = 0. The following `divu` `9 / 3` → `{0, 3}` after the full latency.
- With `DIV_EARLY_EXIT_EN` defined: `div` `-3 / 5` → `ready_o` at t+2, `result_o` = `{0xFFFFFFFD, 0}`. Without it, the same result appears at t+33.

Source files
------------

// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encoding, handshake levels and helpers for the
// iterative divider.
package div_iter_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

    // Two's-complement negate when en is set, pass-through otherwise.
    // Used both for magnitude extraction and for the final sign fixup.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: 32-bit radix-2 restoring divider for MIPS div/divu.
// Produces {remainder, quotient}; one quotient bit per cycle, result and
// ready are registered and held while start_i stays high in DivEnd.
// Optional build macro: DIV_EARLY_EXIT_EN (skip iteration when |dividend| < |divisor|).
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_dvd_q, neg_dvd_d;
    logic        neg_quo_q, neg_quo_d;
    logic [63:0] result_d;
    logic        ready_d;
`ifdef DIV_EARLY_EXIT_EN
    logic        early_q, early_d;
`endif

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [33:0] diff;
    logic [64:0] step;

    // Next-state, datapath step and registered-output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvsr_d    = dvsr_q;
        neg_dvd_d = neg_dvd_q;
        neg_quo_d = neg_quo_q;
        result_d  = result_o;
        ready_d   = ready_o;
`ifdef DIV_EARLY_EXIT_EN
        early_d   = early_q;
`endif

        dvd_mag = neg_if(opdata1_i, signed_div_i & opdata1_i[31]);
        dvs_mag = neg_if(opdata2_i, signed_div_i & opdata2_i[31]);

        // work_q[64] is always 0 between steps (partial remainder < divisor),
        // so work_q[64:31] is the shifted upper part zero-extended to 34 bits;
        // the extra bit keeps the borrow unambiguous for divisors >= 2^31.
        diff = work_q[64:31] - {2'b00, dvsr_q};
        if (diff[33]) begin
            step = {work_q[63:0], 1'b0};
        end else begin
            step = {diff[32:0], work_q[30:0], 1'b1};
        end

        unique case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = {ZERO_WORD, ZERO_WORD};
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == ZERO_WORD) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        work_d    = {33'b0, dvd_mag};
                        dvsr_d    = dvs_mag;
                        neg_dvd_d = signed_div_i & opdata1_i[31];
                        neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
`ifdef DIV_EARLY_EXIT_EN
                        early_d   = (dvd_mag < dvs_mag);
`endif
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                ready_d  = DIV_RESULT_READY;
                result_d = {ZERO_WORD, ZERO_WORD};
            end
            DIV_ON: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end
`ifdef DIV_EARLY_EXIT_EN
                // Early exit spends this one DivOn cycle so ready still lands at t+2;
                // the quotient is 0 and the remainder is the dividend itself.
                else if (early_q) begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {neg_if(work_q[31:0], neg_dvd_q), ZERO_WORD};
                end
`endif
                else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DIV_END;
                        ready_d  = DIV_RESULT_READY;
                        result_d = {neg_if(step[63:32], neg_dvd_q),
                                    neg_if(step[31:0], neg_quo_q)};
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = {ZERO_WORD, ZERO_WORD};
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            dvsr_q    <= '0;
            neg_dvd_q <= 1'b0;
            neg_quo_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
`ifdef DIV_EARLY_EXIT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvsr_q    <= dvsr_d;
            neg_dvd_q <= neg_dvd_d;
            neg_quo_q <= neg_quo_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
`ifdef DIV_EARLY_EXIT_EN
            early_q   <= early_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter; directed cases plus
// randomized operations compared against an arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division; x/0 defined as 0.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges after the start edge until ready is seen.
    function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? 32'd0 - a : a;
        mb = (sgn && b[31]) ? 32'd0 - b : b;
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        if (ma < mb) return 1;
`endif
        return 32;
    endfunction

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        int          edges;
        logic        seen;
        logic [63:0] exp;
        exp   = ref_div(sgn, a, b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        // operands are don't-care after the start edge
        signed_div_i = 1'($urandom);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        edges = 0;
        seen  = 1'b0;
        while (edges < 100 && !seen) begin
            @(posedge clk);
            #1;
            edges++;
            seen = ready_o;
        end
        check({tag, "_ready"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(edges), 64'(ref_lat(sgn, a, b)));
        check({tag, "_res"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
            check({tag, "_hold_res"}, result_o, exp);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_res"}, result_o, 64'd0);
    endtask

    task automatic watch_idle(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            seen = seen | ready_o;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 2);
        check("model_100_7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div("div_by_zero", 1'b0, 32'h0000_1234, 32'd0, 1);
        run_div("div_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div("div_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        run_div("divu_big_dvs", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        // annul mid-operation
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        watch_idle("annul_no_ready", 40);
        run_div("divu_after_annul", 1'b0, 32'hFFFF_FFFF, 32'h10, 0);

        // annul wins over start in DivFree (divide-by-zero would otherwise finish fast)
        @(negedge clk);
        opdata1_i = 32'h1234;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        watch_idle("annul_wins_free", 6);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        // reset mid-operation
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rdy", 64'(ready_o), 64'd0);
        check("rst_mid_res", result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        watch_idle("rst_abandon", 40);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 0);

        // reset while holding a finished result
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_end_rdy", 64'(ready_o), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);

        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                3: begin b = $urandom; a = $urandom_range(0, 50); end
                default: b = $urandom;
            endcase
            if (b == 32'd0 && sel != 0) b = 32'd1;
            run_div("rand", sgn, a, b, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
